// File: rtl/onchip_arb_pkg.sv
// Shared constants and FSM state type for the two-port on-chip memory arbiter.
package onchip_arb_pkg;
  localparam int NUM_RQ       = 2;
  localparam int LOCK_TIMEOUT = 16;
  localparam int PERF_CNT_W   = 32;
  localparam int TMO_W        = $clog2(LOCK_TIMEOUT);

  typedef enum logic {ARB, LOCKED} arb_state_e;
endpackage

// File: rtl/onchip_arb_rr.sv
// Two-way round-robin picker: on contention the port not granted most recently wins.
module onchip_arb_rr
  import onchip_arb_pkg::*;
(
  input  logic [NUM_RQ-1:0] requests,
  input  logic              pointer,
  output logic [NUM_RQ-1:0] grant
);
  always_comb begin
    grant = '0;
    if (requests[0] && requests[1]) grant[~pointer] = 1'b1;
    else                            grant = requests;
  end
endmodule

// File: rtl/pcie_cv_qsys_onchip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM with lock support.
// Define ONCHIP_ARB_PERF_EN to add per-port grant/stall performance counters.
module pcie_cv_qsys_onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*ADDR_W-1:0]      rq_address,
  input  logic [2*BE_W-1:0]        rq_byteenable,
  input  logic [1:0]               rq_read,
  input  logic [1:0]               rq_write,
  input  logic [2*DATA_W-1:0]      rq_writedata,
  input  logic [1:0]               rq_lock,
  output logic [1:0]               rq_waitrequest,
  output logic [DATA_W-1:0]        rq_readdata,
  output logic [1:0]               rq_readdatavalid,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [BE_W-1:0]          mem_byteenable,
  output logic [DATA_W-1:0]        mem_writedata,
  output logic                     mem_chipselect,
  output logic                     mem_write,
  output logic                     mem_clken,
  input  logic [DATA_W-1:0]        mem_readdata
`ifdef ONCHIP_ARB_PERF_EN
  ,
  output logic [NUM_RQ*PERF_CNT_W-1:0] perf_grant_cnt,
  output logic [NUM_RQ*PERF_CNT_W-1:0] perf_stall_cnt
`endif
);
  logic [NUM_RQ-1:0] req, rr_grant, grant, acc, rd_pend;
  arb_state_e        state;
  logic              owner, last, sel;
  logic [TMO_W-1:0]  tmo;

  assign req = rq_read | rq_write;

  onchip_arb_rr u_rr (.requests(req), .pointer(last), .grant(rr_grant));

  always_comb begin
    grant = '0;
    if (!reset) begin
      if (state == ARB) grant = rr_grant;
      else              grant[owner] = req[owner];
    end
  end

  assign acc            = req & grant;
  assign sel            = grant[1];
  assign rq_waitrequest = reset ? 2'b11 : (req & ~grant);

  assign mem_address    = sel ? rq_address[2*ADDR_W-1:ADDR_W]    : rq_address[ADDR_W-1:0];
  assign mem_byteenable = sel ? rq_byteenable[2*BE_W-1:BE_W]     : rq_byteenable[BE_W-1:0];
  assign mem_writedata  = sel ? rq_writedata[2*DATA_W-1:DATA_W]  : rq_writedata[DATA_W-1:0];
  assign mem_chipselect = |grant;
  assign mem_write      = |(grant & rq_write);
  assign mem_clken      = ~reset;

  assign rq_readdata      = mem_readdata;
  assign rq_readdatavalid = rd_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB;
      owner   <= 1'b0;
      last    <= 1'b1;
      tmo     <= '0;
      rd_pend <= '0;
    end else begin
      // read+write together is a write, so it never returns data
      rd_pend <= acc & rq_read & ~rq_write;
      if (|acc) last <= acc[1];
      case (state)
        ARB: begin
          if (|(acc & rq_lock)) begin
            state <= LOCKED;
            owner <= acc[1];
            tmo   <= '0;
          end
        end
        LOCKED: begin
          if (acc[owner] && !rq_lock[owner]) begin
            state <= ARB;
          end else if (req[owner]) begin
            tmo <= '0;
          end else if (tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
            state <= ARB;
            last  <= owner;
            tmo   <= '0;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef ONCHIP_ARB_PERF_EN
  for (genvar i = 0; i < NUM_RQ; i++) begin : g_perf
    logic [PERF_CNT_W-1:0] gcnt, scnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        gcnt <= '0;
        scnt <= '0;
      end else begin
        if (acc[i] && gcnt != '1)            gcnt <= gcnt + PERF_CNT_W'(1);
        if (rq_waitrequest[i] && scnt != '1) scnt <= scnt + PERF_CNT_W'(1);
      end
    end
    assign perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = gcnt;
    assign perf_stall_cnt[i*PERF_CNT_W +: PERF_CNT_W] = scnt;
  end
`else
  // default build carries no performance counters
`endif
endmodule

// File: tb/tb_pcie_cv_qsys_onchip_mem_arbiter.sv
// Scoreboard bench: a behavioural RAM sits behind the arbiter; expected reads are queued on acceptance.
module tb_pcie_cv_qsys_onchip_mem_arbiter;
  localparam int ADDR_W = 10, DATA_W = 32, BE_W = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [2*ADDR_W-1:0] rq_address = '0;
  logic [2*BE_W-1:0]   rq_byteenable = '0;
  logic [1:0]          rq_read = '0, rq_write = '0, rq_lock = '0;
  logic [2*DATA_W-1:0] rq_writedata = '0;
  logic [1:0]          rq_waitrequest, rq_readdatavalid;
  logic [DATA_W-1:0]   rq_readdata, mem_writedata, mem_readdata;
  logic [ADDR_W-1:0]   mem_address;
  logic [BE_W-1:0]     mem_byteenable;
  logic                mem_chipselect, mem_write, mem_clken;
`ifdef ONCHIP_ARB_PERF_EN
  logic [63:0]         perf_grant_cnt, perf_stall_cnt;
`endif

  pcie_cv_qsys_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .rq_address(rq_address), .rq_byteenable(rq_byteenable),
    .rq_read(rq_read), .rq_write(rq_write), .rq_writedata(rq_writedata),
    .rq_lock(rq_lock), .rq_waitrequest(rq_waitrequest),
    .rq_readdata(rq_readdata), .rq_readdatavalid(rq_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
`ifdef ONCHIP_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, vld_pulses = 0;
  bit mon_en = 1'b0;
  typedef struct {int port; logic [31:0] data; int due;} rd_exp_t;
  rd_exp_t sb[$];
  logic [31:0] mem [1024];
  logic [31:0] shadow [1024];
  bit mem_inited = 1'b0;
  int exp_g[2], exp_s[2];

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // behavioural RAM with registered q, one cycle after the address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_inited <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      for (int b = 0; b < 4; b++)
        if (mem_write && mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= mem[mem_address];
    end
  end

  // scoreboard: pop reads due this cycle and compare against readdatavalid/readdata
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      logic [1:0]  ev;
      logic [31:0] ed;
      ev = '0;
      ed = '0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        if (sb[0].due == cyc) begin ev[sb[0].port] = 1'b1; ed = sb[0].data; end
        void'(sb.pop_front());
      end
      checks++;
      if (rq_readdatavalid !== ev) begin
        $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, rq_readdatavalid, ev);
        failures++;
      end else if (ev != 2'b00) begin
        vld_pulses++;
        checks++;
        if (rq_readdata !== ed) begin
          $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, rq_readdata, ed);
          failures++;
        end
      end
    end
  end

  task automatic idle();
    rq_read = '0; rq_write = '0; rq_lock = '0;
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input bit l,
                          input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    rq_read[p] = r; rq_write[p] = w; rq_lock[p] = l;
    rq_address[p*10 +: 10] = a; rq_byteenable[p*4 +: 4] = be; rq_writedata[p*32 +: 32] = d;
  endtask

  // record what the expected grant accepted this cycle, then advance to posedge+1
  task automatic commit_cycle(input logic [1:0] exp_wait);
    logic [1:0] acc;
    logic [9:0] a;
    acc = (rq_read | rq_write) & ~exp_wait;
    for (int p = 0; p < 2; p++) begin
      exp_s[p] += int'(exp_wait[p]);
      if (acc[p]) begin
        exp_g[p]++;
        a = rq_address[p*10 +: 10];
        if (rq_write[p]) begin
          for (int b = 0; b < 4; b++)
            if (rq_byteenable[p*4+b]) shadow[a][8*b +: 8] = rq_writedata[p*32+8*b +: 8];
        end else begin
          sb.push_back('{p, shadow[a], cyc + 1});
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rq_read = 2'b11;
    @(negedge clk);
    checks++;
    if ({rq_waitrequest, rq_readdatavalid, mem_chipselect, mem_write, mem_clken} !== 7'b11_00_000) begin
      $display("FAIL reset_outputs got wait=%b vld=%b cs=%b wr=%b clken=%b exp wait=11 vld=00 cs=0 wr=0 clken=0",
               rq_waitrequest, rq_readdatavalid, mem_chipselect, mem_write, mem_clken);
      failures++;
    end
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_clken !== 1'b1 || rq_waitrequest !== 2'b00) begin
      $display("FAIL reset_release got clken=%b wait=%b exp clken=1 wait=00", mem_clken, rq_waitrequest);
      failures++;
    end
    commit_cycle(2'b00);
  endtask

  task automatic test_alternate();
    logic [9:0] a[2];
    logic [1:0] exp;
    int v0;
    a[0] = 10'h100; a[1] = 10'h200;
    v0 = vld_pulses;
    for (int k = 0; k < 8; k++) begin
      set_port(0, 1, 0, 0, a[0], 4'hF, 32'h0);
      set_port(1, 1, 0, 0, a[1], 4'hF, 32'h0);
      exp = (k % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if (rq_waitrequest !== exp) begin
        $display("FAIL alt_wait k=%0d got=%b exp=%b", k, rq_waitrequest, exp);
        failures++;
      end
      commit_cycle(exp);
      if (exp[0]) a[1]++; else a[0]++;
    end
    idle();
    @(negedge clk);
    commit_cycle(2'b00);
    checks++;
    if (vld_pulses - v0 != 8) begin
      $display("FAIL alt_pulses got=%0d exp=8", vld_pulses - v0);
      failures++;
    end
  endtask

  task automatic test_write_read();
    idle();
    set_port(0, 0, 1, 0, 10'h3FF, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (rq_waitrequest !== 2'b00 || mem_write !== 1'b1 || mem_address !== 10'h3FF || mem_writedata !== 32'hDEADBEEF) begin
      $display("FAIL wr_mem got wait=%b wr=%b addr=%h data=%h exp wait=00 wr=1 addr=3ff data=deadbeef",
               rq_waitrequest, mem_write, mem_address, mem_writedata);
      failures++;
    end
    commit_cycle(2'b00);
    set_port(0, 1, 0, 0, 10'h3FF, 4'hF, 32'h0);
    @(negedge clk);
    checks++;
    if (rq_waitrequest !== 2'b00 || mem_write !== 1'b0 || mem_chipselect !== 1'b1) begin
      $display("FAIL rd_mem got wait=%b wr=%b cs=%b exp wait=00 wr=0 cs=1", rq_waitrequest, mem_write, mem_chipselect);
      failures++;
    end
    commit_cycle(2'b00);
    idle();
    @(negedge clk);
    checks++;
    if (rq_readdatavalid !== 2'b01 || rq_readdata !== 32'hDEADBEEF) begin
      $display("FAIL rd_data got vld=%b data=%h exp vld=01 data=deadbeef", rq_readdatavalid, rq_readdata);
      failures++;
    end
    commit_cycle(2'b00);
  endtask

  task automatic test_byteenable();
    idle();
    set_port(1, 0, 1, 0, 10'h000, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    commit_cycle(2'b00);
    set_port(1, 0, 1, 0, 10'h000, 4'b0101, 32'h11223344);
    @(negedge clk);
    checks++;
    if (rq_waitrequest !== 2'b00 || mem_byteenable !== 4'b0101) begin
      $display("FAIL be_mem got wait=%b be=%b exp wait=00 be=0101", rq_waitrequest, mem_byteenable);
      failures++;
    end
    commit_cycle(2'b00);
    set_port(1, 1, 0, 0, 10'h000, 4'hF, 32'h0);
    @(negedge clk);
    commit_cycle(2'b00);
    idle();
    @(negedge clk);
    checks++;
    if (rq_readdatavalid !== 2'b10 || rq_readdata !== 32'hFF22FF44) begin
      $display("FAIL be_data got vld=%b data=%h exp vld=10 data=ff22ff44", rq_readdatavalid, rq_readdata);
      failures++;
    end
    commit_cycle(2'b00);
  endtask

  task automatic test_lock();
    logic [1:0] exp[4];
    exp = '{2'b10, 2'b10, 2'b10, 2'b00};
    idle();
    // locked read, idle-while-locked, unlocked write, then port 1 finally served
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_port(0, 1, 0, 1, 10'h3FF, 4'hF, 32'h0);
        1: set_port(0, 0, 0, 1, 10'h3FF, 4'hF, 32'h0);
        2: set_port(0, 0, 1, 0, 10'h020, 4'hF, 32'hCAFEF00D);
        default: set_port(0, 0, 0, 0, 10'h020, 4'hF, 32'h0);
      endcase
      set_port(1, 1, 0, 0, 10'h010, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (rq_waitrequest !== exp[k]) begin
        $display("FAIL lock_wait step=%0d got=%b exp=%b", k, rq_waitrequest, exp[k]);
        failures++;
      end
      commit_cycle(exp[k]);
    end
    // timeout: lock, 8 idle, re-request (clears counter), 16 idle, then unlocked
    idle();
    set_port(0, 1, 0, 1, 10'h020, 4'hF, 32'h0);
    @(negedge clk);
    commit_cycle(2'b00);
    for (int k = 0; k < 25; k++) begin
      set_port(0, (k == 8), 0, 1, 10'h020, 4'hF, 32'h0);
      set_port(1, 1, 0, 0, 10'h011, 4'hF, 32'h0);
      @(negedge clk);
      checks++;
      if (rq_waitrequest !== 2'b10) begin
        $display("FAIL lock_hold k=%0d got=%b exp=10", k, rq_waitrequest);
        failures++;
      end
      commit_cycle(2'b10);
    end
    set_port(0, 1, 0, 0, 10'h020, 4'hF, 32'h0);
    @(negedge clk);
    checks++;
    if (rq_waitrequest !== 2'b01) begin
      $display("FAIL lock_timeout got=%b exp=01", rq_waitrequest);
      failures++;
    end
    commit_cycle(2'b01);
    set_port(1, 0, 0, 0, 10'h011, 4'hF, 32'h0);
    @(negedge clk);
    commit_cycle(2'b00);
    idle();
    @(negedge clk);
    commit_cycle(2'b00);
  endtask

  task automatic test_reset_midread();
    idle();
    set_port(0, 1, 0, 0, 10'h3FF, 4'hF, 32'h0);
    @(negedge clk);
    commit_cycle(2'b00);
    idle();
    reset = 1'b1;
    sb.delete();
    exp_g = '{0, 0};
    exp_s = '{0, 0};
    @(negedge clk);
    checks++;
    if (rq_readdatavalid !== 2'b00 || rq_waitrequest !== 2'b11) begin
      $display("FAIL rst_mid got vld=%b wait=%b exp vld=00 wait=11", rq_readdatavalid, rq_waitrequest);
      failures++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    commit_cycle(2'b00);
    set_port(0, 1, 0, 0, 10'h005, 4'hF, 32'h0);
    set_port(1, 1, 0, 0, 10'h006, 4'hF, 32'h0);
    @(negedge clk);
    checks++;
    if (rq_waitrequest !== 2'b10) begin
      $display("FAIL rst_first_win got=%b exp=10", rq_waitrequest);
      failures++;
    end
    commit_cycle(2'b10);
    idle();
    @(negedge clk);
    commit_cycle(2'b00);
  endtask

`ifdef ONCHIP_ARB_PERF_EN
  task automatic test_perf();
    logic [1:0] exp;
    for (int k = 0; k < 10; k++) begin
      set_port(0, 1, 0, 0, 10'(k), 4'hF, 32'h0);
      set_port(1, 1, 0, 0, 10'(k + 64), 4'hF, 32'h0);
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      commit_cycle(exp);
    end
    idle();
    @(negedge clk);
    commit_cycle(2'b00);
    checks++;
    if (perf_grant_cnt !== {32'(exp_g[1]), 32'(exp_g[0])}) begin
      $display("FAIL perf_grant got=%h exp=%h", perf_grant_cnt, {32'(exp_g[1]), 32'(exp_g[0])});
      failures++;
    end
    checks++;
    if (perf_stall_cnt !== {32'(exp_s[1]), 32'(exp_s[0])}) begin
      $display("FAIL perf_stall got=%h exp=%h", perf_stall_cnt, {32'(exp_s[1]), 32'(exp_s[0])});
      failures++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    exp_g = '{0, 0};
    exp_s = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alternate();
    test_write_read();
    test_byteenable();
    test_lock();
    test_reset_midread();
`ifdef ONCHIP_ARB_PERF_EN
    test_perf();
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcie_cv_qsys_onchip_mem_arbiter.md
PCIE_CV_QSYS_ONCHIP_MEM_ARBITER -- requirements
Module: pcie_cv_qsys_onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 10, word-address width of the shared memory.
REQ-002 SHALL have parameter DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rq_address  in  2*ADDR_W  requester i word address, slice i.
REQ-006 SHALL have port rq_byteenable  in  2*BE_W  requester i byte enables.
REQ-007 SHALL have port rq_read  in  2  requester i read request.
REQ-008 SHALL have port rq_write  in  2  requester i write request.
REQ-009 SHALL have port rq_writedata  in  2*DATA_W  requester i write data.
REQ-010 SHALL have port rq_lock  in  2  requester i holds grant after this transfer.
REQ-011 SHALL have port rq_waitrequest  out  2  requester i stalled, hold request stable.
REQ-012 SHALL have port rq_readdata  out  DATA_W  read data, shared, qualified by readdatavalid.
REQ-013 SHALL have port rq_readdatavalid  out  2  one-cycle pulse, read data for requester i.
REQ-014 SHALL have ports mem_address/mem_byteenable/mem_writedata  out  ADDR_W/BE_W/DATA_W  to memory.
REQ-015 SHALL have ports mem_chipselect, mem_write, mem_clken  out  1  memory controls.
REQ-016 SHALL have port mem_readdata  in  DATA_W  memory q, valid one cycle after address.

Function
REQ-017 Request i = rq_read[i]|rq_write[i]; read and write both high SHALL be treated as a write (no readdatavalid).
REQ-018 At most one grant per cycle; grant SHALL be combinational from current requests and state (zero-wait when uncontended).
REQ-019 In state ARB with both requesting, SHALL grant the port not granted most recently (round-robin); last-grant pointer updates on each acceptance.
REQ-020 rq_waitrequest[i] SHALL equal request[i] & ~grant[i]; acceptance = request & grant.
REQ-021 mem_* SHALL mirror the granted port's fields; mem_chipselect = any grant; mem_write = granted write; mem_clken = 1 outside reset.
REQ-022 Read accepted in cycle N SHALL give rq_readdatavalid[i]=1 in cycle N+1 only, rq_readdata = mem_readdata; back-to-back reads from alternating ports SHALL be supported every cycle.
REQ-023 Acceptance with rq_lock[i]=1 SHALL move FSM ARB -> LOCKED(i); in LOCKED(i) only port i is grantable.
REQ-024 LOCKED(i) -> ARB on an accepted port-i transfer with rq_lock[i]=0, or after 16 consecutive cycles with no port-i request (4-bit timeout counter, cleared by any port-i request).
REQ-025 On unlock via timeout the round-robin pointer SHALL point away from i.

Reset
REQ-026 While reset asserted: rq_waitrequest=2'b11, rq_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-027 Reset values: FSM=ARB, pointer so port 0 wins first contention, timeout=0, pending-read owner cleared.
REQ-028 Reset mid-read SHALL drop the pending readdatavalid; no pulse after release.

Configuration
REQ-029 Macro ONCHIP_ARB_PERF_EN defined: ports perf_grant_cnt (out, 2*32) and perf_stall_cnt (out, 2*32) SHALL count accepted transfers and waitrequest cycles per port, saturating at 2^32-1, reset to 0.
REQ-030 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package onchip_arb_pkg SHALL hold NUM_RQ=2, LOCK_TIMEOUT=16, PERF_CNT_W=32 and the FSM state enum (ARB, LOCKED).
REQ-032 Round-robin grant logic SHALL be sub-module onchip_arb_rr (requests, pointer -> one-hot grant).

Verification
REQ-033 Port 0 write 0x3FF<-0xDEADBEEF, BE=4'hF, then read 0x3FF -> no waitrequest, readdatavalid[0] one cycle after read, data 0xDEADBEEF.
REQ-034 Both ports read every cycle for 8 cycles -> grants alternate 0,1,0,1..., each port stalled every other cycle, 8 valid pulses total.
REQ-035 Port 1 write BE=4'b0101 data 0x11223344 over 0xFFFFFFFF at 0x000 -> read returns 0xFF22FF44.
REQ-036 Port 0 locked read then unlocked write with port 1 requesting throughout -> port 1 waits until cycle after port-0 write; 16 idle cycles with lock held -> unlock.
REQ-037 Reset asserted cycle after read acceptance -> no readdatavalid; after release port 0 wins first contention.
REQ-038 ONCHIP_ARB_PERF_EN build, 5 contended accesses each -> perf_grant_cnt = 5/5, stall counts match waitrequest cycles.
